trace_packet_decoder: RTL and testbench
=======================================

# trace_packet_decoder

Host-side-in-fabric decoder for the RAM tracer packet stream. Consumes the 4-byte-per-packet trace byte stream, the same stream the tracer pushes into the USB FIFO, and regains packet alignment from the sync bit. Rebuilds each logged RAM access as a full event: absolute 32-bit timestamp, word address, data and byte enables. It sits on loopback and self-test paths: tracer output → decoder → checker/scoreboard, or a second FPGA reading a captured stream.

## Interface

Parameters:
- `TIME_W`, default 32: width of the absolute timestamp accumulator. Wraps modulo 2^TIME_W.
- `IDX_W`, default 8: width of the burst word index. Saturates at all-ones.

Ports:
- `mclk` input 1: clock.
- `reset` input 1: asynchronous, active-high.
- `in_data` input 8: trace stream byte.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_ready` output 1: the byte is consumed when `in_valid && in_ready`.
- `ev_valid` output 1: event register holds an event.
- `ev_ready` input 1: consumer accepts the event.
- `ev_type` output 2: 00 address, 01 read word, 10 write word.
- `ev_addr` output 23: for address events, the latched address; for data events, base + index, mod 2^23.
- `ev_data` output 16: RAM data word. 0 for address events.
- `ev_ublb` output 2: byte-lane field as carried in the packet. 0 for address events.
- `ev_index` output IDX_W: word index within the burst, counting from 0.
- `ev_time` output TIME_W: absolute timestamp after this packet's delta is applied.
- `err_sync` output 1: one-cycle pulse when a byte is discarded or a packet is restarted.
- `err_rsvd` output 1: one-cycle pulse when a packet has nonzero reserved bits.

## Operation

Packet byte layout:
- B0 = {1, type[1:0], payload[22:18]}
- B1 = {0, payload[17:11]}
- B2 = {0, payload[10:4]}
- B3 = {0, payload[3:0], 3'b000}

Data payload layout: payload = {ts5[4:0], ublb[1:0], data[15:0]}.

Receive states: HUNT, GOT1, GOT2, GOT3.
- HUNT: a byte with bit7=1 is latched as B0 → GOT1. A byte with bit7=0 is dropped and pulses `err_sync`.
- GOT1 / GOT2 / GOT3: a byte with bit7=0 is accepted as the next byte. A byte with bit7=1 aborts the current packet, pulses `err_sync`, is taken as a new B0 → GOT1.
- GOT3 accepting B3 completes the packet → GOT1-ready state (HUNT semantics: the next byte must be a header).
- Nonzero B3[2:0]: pulse `err_rsvd`, discard the packet, change no state.

Packet processing on completion:
- Type 00 (address): base ← payload, index ← 0, time unchanged. Emit an address event with `ev_index`=0.
- Type 01 / 10 (read / write): time ← time + ts5. Emit a data event with the current index. Then index ← index + 1, saturating at 2^IDX_W−1.
- Type 11 (timestamp): time ← time + zero-extended payload. No event emitted.

Other rules:
- Data packets before any address packet use base=0.
- Reset values: state HUNT; `in_ready`=1; `ev_valid`=0; all `ev_*` outputs, time, base and index = 0; `err_*`=0.

## Timing

- Throughput: 1 byte/cycle while not stalled, so 1 packet per 4 cycles.
- Latency: B3 accepted at cycle N → `ev_valid`=1 and all `ev_*` fields registered at N+1. Timestamp packets update internal time at N+1 with no event.
- `in_ready` = !ev_valid || ev_ready.
- Handshake: `ev_*` fields hold stable while `ev_valid && !ev_ready`. If an event is taken and a new packet completes in the same cycle, the new event loads at once with `ev_valid` held at 1.
- Error pulses fire in the cycle after the offending byte is accepted.
- Reset mid-packet: the partial packet is lost; decoding restarts in HUNT.

## Structure

- Shared package `trace_pkt_pkg` holds:
  - packet type codes (PKT_ADDR=00, PKT_READ=01, PKT_WRITE=10, PKT_TIME=11);
  - the sync-bit position;
  - payload field widths and offsets (ADDR_W=23, TS5_W=5, UBLB_W=2, DATA_W=16).
- One sub-module, `trace_byte_framer`: the HUNT/GOT state machine plus the byte shift register. It outputs {type, payload, pkt_valid, err_sync, err_rsvd}.
- The top level holds time, base, index and the event register.

## Test plan

- Single packet: bytes 0x80,0x00,0x00,0x08 → address event, addr=0x000001, time=0. Then write packet with ts5=3, ublb=3, data=0xBEEF → write event, addr=0x000001, index=0, time=3.
- Burst: address 0x7FFFFF, then 3 read packets each with ts5=1 → addrs 0x7FFFFF, 0x000000, 0x000001; index 0,1,2; time 1,2,3.
- Timestamp packet with payload 0x000100, then a read with ts5=31 → no event from the timestamp packet; read event time = 0x11F.
- Resync: stream 0x05, 0x80, 0x00, 0x80, 0x00, 0x00, 0x00 → two `err_sync` pulses (stray byte, aborted packet); one address event, addr=0.
- Backpressure: hold `ev_ready`=0 for 10 cycles with packets queued → `in_ready`=0, `ev_*` stable. On release, events arrive in order with none lost.
- Index saturation and reserved bits: 300 reads after one address → `ev_index` sticks at 255 from read 256 onward. A packet with B3=0x01 → `err_rsvd`=1, no event, time unchanged.

Source files
------------

// File: rtl/trace_pkt_pkg.sv
// Shared definitions for the RAM tracer packet format: type codes, sync bit
// and payload field layout.
package trace_pkt_pkg;

    localparam int SYNC_BIT = 7;

    localparam int ADDR_W    = 23;
    localparam int TS5_W     = 5;
    localparam int UBLB_W    = 2;
    localparam int DATA_W    = 16;
    localparam int RSVD_W    = 3;
    localparam int PAYLOAD_W = ADDR_W;

    localparam int DATA_LSB = 0;
    localparam int UBLB_LSB = DATA_LSB + DATA_W;
    localparam int TS5_LSB  = UBLB_LSB + UBLB_W;

    typedef logic [1:0] pkt_type_t;

    localparam pkt_type_t PKT_ADDR  = 2'b00;
    localparam pkt_type_t PKT_READ  = 2'b01;
    localparam pkt_type_t PKT_WRITE = 2'b10;
    localparam pkt_type_t PKT_TIME  = 2'b11;

    typedef struct packed {
        logic [TS5_W-1:0]  ts5;
        logic [UBLB_W-1:0] ublb;
        logic [DATA_W-1:0] data;
    } data_payload_t;

endpackage

// File: rtl/trace_byte_framer.sv
// Byte-level framer: regains packet alignment from the sync bit and presents
// each complete 4-byte packet as type + payload for one cycle.
module trace_byte_framer
    import trace_pkt_pkg::*;
(
    input  logic                 mclk,
    input  logic                 reset,
    input  logic [7:0]           i_byte,
    input  logic                 i_take,
    output pkt_type_t            o_type,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic                 o_pkt_valid,
    output logic                 o_err_sync,
    output logic                 o_err_rsvd
);

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_GOT1 = 2'd1;
    localparam logic [1:0] ST_GOT2 = 2'd2;
    localparam logic [1:0] ST_GOT3 = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_d;
    logic [6:0] r_hdr;
    logic [6:0] r_b1;
    logic [6:0] r_b2;
    logic       w_sync;

    assign w_sync    = i_byte[SYNC_BIT];
    assign o_type    = r_hdr[6:5];
    assign o_payload = {r_hdr[4:0], r_b1, r_b2, i_byte[6:RSVD_W]};

    always_comb begin
        w_state_d   = r_state;
        o_pkt_valid = 1'b0;
        o_err_sync  = 1'b0;
        o_err_rsvd  = 1'b0;
        if (i_take) begin
            if (w_sync) begin
                // A header always starts a fresh packet, aborting any partial one.
                w_state_d  = ST_GOT1;
                o_err_sync = (r_state != ST_HUNT);
            end else begin
                case (r_state)
                    ST_HUNT: o_err_sync = 1'b1;
                    ST_GOT1: w_state_d = ST_GOT2;
                    ST_GOT2: w_state_d = ST_GOT3;
                    default: begin
                        w_state_d = ST_HUNT;
                        if (i_byte[RSVD_W-1:0] != '0) begin
                            o_err_rsvd = 1'b1;
                        end else begin
                            o_pkt_valid = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HUNT;
            r_hdr   <= '0;
            r_b1    <= '0;
            r_b2    <= '0;
        end else begin
            r_state <= w_state_d;
            if (i_take && w_sync) begin
                r_hdr <= i_byte[6:0];
            end
            if (i_take && !w_sync && r_state == ST_GOT1) begin
                r_b1 <= i_byte[6:0];
            end
            if (i_take && !w_sync && r_state == ST_GOT2) begin
                r_b2 <= i_byte[6:0];
            end
        end
    end

endmodule

// File: rtl/trace_packet_decoder.sv
// Trace stream decoder: rebuilds each logged RAM access as a full event with
// absolute timestamp, burst word address, data and byte lanes.
module trace_packet_decoder
    import trace_pkt_pkg::*;
#(
    parameter int unsigned TIME_W = 32,
    parameter int unsigned IDX_W  = 8
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [1:0]        ev_type,
    output logic [ADDR_W-1:0] ev_addr,
    output logic [DATA_W-1:0] ev_data,
    output logic [UBLB_W-1:0] ev_ublb,
    output logic [IDX_W-1:0]  ev_index,
    output logic [TIME_W-1:0] ev_time,
    output logic              err_sync,
    output logic              err_rsvd
);

    logic                 w_take;
    pkt_type_t            w_type;
    logic [PAYLOAD_W-1:0] w_payload;
    logic                 w_pkt_valid;
    logic                 w_err_sync;
    logic                 w_err_rsvd;
    data_payload_t        w_dp;
    logic [TIME_W-1:0]    w_time_data;
    logic [TIME_W-1:0]    w_time_stamp;
    logic [IDX_W-1:0]     w_index_next;
    logic [ADDR_W-1:0]    w_data_addr;

    logic [TIME_W-1:0] r_time;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_index;
    logic              r_ev_valid;
    pkt_type_t         r_ev_type;
    logic [ADDR_W-1:0] r_ev_addr;
    logic [DATA_W-1:0] r_ev_data;
    logic [UBLB_W-1:0] r_ev_ublb;
    logic [IDX_W-1:0]  r_ev_index;
    logic [TIME_W-1:0] r_ev_time;
    logic              r_err_sync;
    logic              r_err_rsvd;

    // A byte can only complete a packet when the event register is free or draining.
    assign in_ready = !r_ev_valid || ev_ready;
    assign w_take   = in_valid && in_ready;

    trace_byte_framer u_framer (
        .mclk        (mclk),
        .reset       (reset),
        .i_byte      (in_data),
        .i_take      (w_take),
        .o_type      (w_type),
        .o_payload   (w_payload),
        .o_pkt_valid (w_pkt_valid),
        .o_err_sync  (w_err_sync),
        .o_err_rsvd  (w_err_rsvd)
    );

    assign w_dp         = w_payload;
    assign w_time_data  = r_time + TIME_W'(w_dp.ts5);
    assign w_time_stamp = r_time + TIME_W'(w_payload);
    assign w_index_next = (r_index == '1) ? r_index : r_index + 1'b1;
    assign w_data_addr  = r_base + ADDR_W'(r_index);

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_time     <= '0;
            r_base     <= '0;
            r_index    <= '0;
            r_ev_valid <= 1'b0;
            r_ev_type  <= PKT_ADDR;
            r_ev_addr  <= '0;
            r_ev_data  <= '0;
            r_ev_ublb  <= '0;
            r_ev_index <= '0;
            r_ev_time  <= '0;
            r_err_sync <= 1'b0;
            r_err_rsvd <= 1'b0;
        end else begin
            r_err_sync <= w_err_sync;
            r_err_rsvd <= w_err_rsvd;
            if (w_pkt_valid) begin
                case (w_type)
                    PKT_ADDR: begin
                        r_base     <= w_payload;
                        r_index    <= '0;
                        r_ev_valid <= 1'b1;
                        r_ev_type  <= w_type;
                        r_ev_addr  <= w_payload;
                        r_ev_data  <= '0;
                        r_ev_ublb  <= '0;
                        r_ev_index <= '0;
                        r_ev_time  <= r_time;
                    end
                    PKT_READ, PKT_WRITE: begin
                        r_time     <= w_time_data;
                        r_index    <= w_index_next;
                        r_ev_valid <= 1'b1;
                        r_ev_type  <= w_type;
                        r_ev_addr  <= w_data_addr;
                        r_ev_data  <= w_dp.data;
                        r_ev_ublb  <= w_dp.ublb;
                        r_ev_index <= r_index;
                        r_ev_time  <= w_time_data;
                    end
                    default: begin
                        r_time <= w_time_stamp;
                        if (ev_ready) begin
                            r_ev_valid <= 1'b0;
                        end
                    end
                endcase
            end else if (ev_ready) begin
                r_ev_valid <= 1'b0;
            end
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_type  = r_ev_type;
    assign ev_addr  = r_ev_addr;
    assign ev_data  = r_ev_data;
    assign ev_ublb  = r_ev_ublb;
    assign ev_index = r_ev_index;
    assign ev_time  = r_ev_time;
    assign err_sync = r_err_sync;
    assign err_rsvd = r_err_rsvd;

endmodule

// File: tb/tb_trace_packet_decoder.sv
// Bench for trace_packet_decoder: packets are built at the packet level, the
// expected events and error pulses are derived from the packet rules.
module tb_trace_packet_decoder;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [1:0]  ev_type;
    logic [22:0] ev_addr;
    logic [15:0] ev_data;
    logic [1:0]  ev_ublb;
    logic [7:0]  ev_index;
    logic [31:0] ev_time;
    logic        err_sync;
    logic        err_rsvd;

    always #5 mclk = ~mclk;

    trace_packet_decoder #(
        .TIME_W (32),
        .IDX_W  (8)
    ) dut (
        .mclk     (mclk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_type  (ev_type),
        .ev_addr  (ev_addr),
        .ev_data  (ev_data),
        .ev_ublb  (ev_ublb),
        .ev_index (ev_index),
        .ev_time  (ev_time),
        .err_sync (err_sync),
        .err_rsvd (err_rsvd)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       ev;
        logic       esync;
        logic       ersvd;
    } byte_t;

    typedef struct packed {
        logic [1:0]  t;
        logic [22:0] a;
        logic [15:0] d;
        logic [1:0]  u;
        logic [7:0]  i;
        logic [31:0] tm;
    } ev_t;

    byte_t       bq[$];
    ev_t         eq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_time = '0;
    logic [22:0] m_base = '0;
    int          m_index = 0;
    bit          pend_abort = 0;
    bit          exp_valid = 0;
    logic [82:0] saved = '0;
    int          bp_hold = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_byte(input logic [7:0] b, input bit ev, input bit es,
                                      input bit er);
        byte_t it;
        it.b = b;
        it.ev = ev;
        it.esync = es;
        it.ersvd = er;
        bq.push_back(it);
    endfunction

    // Applies the packet rules to the model and queues the four bytes.
    function automatic void push_pkt(input logic [1:0] t, input logic [22:0] pl,
                                     input logic [2:0] rsvd);
        ev_t e;
        bit  has_ev = 0;
        e = '0;
        if (rsvd == 3'd0) begin
            if (t == 2'b00) begin
                m_base  = pl;
                m_index = 0;
                e.t = t; e.a = pl; e.tm = m_time;
                has_ev = 1;
            end else if (t == 2'b11) begin
                m_time = m_time + {9'd0, pl};
            end else begin
                m_time = m_time + {27'd0, pl[22:18]};
                e.t = t;
                e.a = m_base + m_index[22:0];
                e.d = pl[15:0];
                e.u = pl[17:16];
                e.i = m_index[7:0];
                e.tm = m_time;
                has_ev = 1;
                if (m_index < 255) m_index++;
            end
        end
        push_byte({1'b1, t, pl[22:18]}, 0, pend_abort, 0);
        pend_abort = 0;
        push_byte({1'b0, pl[17:11]}, 0, 0, 0);
        push_byte({1'b0, pl[10:4]}, 0, 0, 0);
        push_byte({1'b0, pl[3:0], rsvd}, has_ev, 0, rsvd != 3'd0);
        if (has_ev) eq.push_back(e);
    endfunction

    function automatic void push_stray(input logic [6:0] v);
        push_byte({1'b0, v}, 0, 1, 0);
    endfunction

    // Header plus k (0..2) continuation bytes; the next header aborts it.
    function automatic void push_abort(input logic [7:0] hdr, input int k, input logic [6:0] fill);
        push_byte({1'b1, hdr[6:0]}, 0, pend_abort, 0);
        for (int j = 0; j < k; j++) push_byte({1'b0, fill}, 0, 0, 0);
        pend_abort = 1;
    endfunction

    task automatic cycle();
        bit          took;
        bit          hs;
        byte_t       it;
        logic [82:0] obs;
        ev_t         e;
        it = '0;
        if (bp_hold > 0) begin
            ev_ready = 1'b0;
            bp_hold--;
        end else begin
            ev_ready = ($urandom_range(0, 3) != 0);
        end
        if (bq.size() > 0 && $urandom_range(0, 4) != 0) begin
            in_valid = 1'b1;
            in_data  = bq[0].b;
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        #1;
        chk("in_ready", in_ready, !exp_valid || ev_ready);
        took = in_valid && in_ready;
        hs   = ev_valid && ev_ready;
        @(posedge mclk);
        if (took) it = bq.pop_front();
        @(negedge mclk);
        obs = {ev_type, ev_addr, ev_data, ev_ublb, ev_index, ev_time};
        chk("err_sync", err_sync, took && it.esync);
        chk("err_rsvd", err_rsvd, took && it.ersvd);
        if (took && it.ev) begin
            chk("ev_expected", eq.size() != 0, 1);
            if (eq.size() != 0) begin
                e = eq.pop_front();
                chk("ev_fields", obs, e);
            end
            exp_valid = 1;
        end else if (hs) begin
            exp_valid = 0;
        end else if (exp_valid) begin
            chk("ev_stable", obs, saved);
        end
        chk("ev_valid", ev_valid, exp_valid);
        saved = obs;
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() > 0 || exp_valid) && n < 20000) begin
            cycle();
            n++;
        end
        chk("drain_timeout", n < 20000, 1);
        chk("events_left", eq.size(), 0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        in_valid = 1'b0;
        @(posedge mclk);
        @(posedge mclk);
        @(negedge mclk);
        reset = 1'b0;
        bq.delete();
        eq.delete();
        m_time = '0;
        m_base = '0;
        m_index = 0;
        pend_abort = 0;
        exp_valid = 0;
        saved = '0;
        #1;
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fields", {ev_type, ev_addr, ev_data, ev_ublb, ev_index, ev_time}, 0);
        chk("rst_err_sync", err_sync, 0);
        chk("rst_err_rsvd", err_rsvd, 0);
    endtask

    initial begin
        int r;
        do_reset();

        // Single address packet 0x80,0x00,0x00,0x08 then a write.
        push_pkt(2'b00, 23'h000001, 3'd0);
        push_pkt(2'b10, {5'd3, 2'd3, 16'hBEEF}, 3'd0);
        drain();

        do_reset();
        push_pkt(2'b00, 23'h7FFFFF, 3'd0);
        for (int k = 0; k < 3; k++) push_pkt(2'b01, {5'd1, 2'($urandom), 16'($urandom)}, 3'd0);
        drain();

        do_reset();
        push_pkt(2'b11, 23'h000100, 3'd0);
        push_pkt(2'b01, {5'd31, 2'd1, 16'h1234}, 3'd0);
        drain();

        // Stray byte, aborted packet, then a clean address packet.
        push_stray(7'h05);
        push_abort(8'h80, 1, 7'h00);
        push_pkt(2'b00, 23'h000000, 3'd0);
        drain();

        // Backpressure with several packets queued.
        bp_hold = 16;
        push_pkt(2'b00, 23'h123456, 3'd0);
        for (int k = 0; k < 4; k++) push_pkt(2'b10, 23'($urandom), 3'd0);
        drain();

        // Index saturation, then a reserved-bit packet that must change nothing.
        push_pkt(2'b00, 23'($urandom), 3'd0);
        for (int k = 0; k < 300; k++) push_pkt(2'b01, 23'($urandom), 3'd0);
        push_pkt(2'b11, 23'h000000, 3'd1);
        push_pkt(2'b01, {5'd7, 18'($urandom)}, 3'd0);
        drain();

        // Reset in the middle of a packet.
        push_byte(8'h81, 0, 0, 0);
        push_byte(8'h12, 0, 0, 0);
        drain();
        do_reset();
        push_pkt(2'b01, {5'd2, 18'($urandom)}, 3'd0);
        push_pkt(2'b00, 23'h000042, 3'd0);
        drain();

        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 1) push_pkt(2'b00, 23'($urandom), 3'd0);
            else if (r <= 5) push_pkt(2'($urandom_range(1, 2)), 23'($urandom), 3'd0);
            else if (r == 6) push_pkt(2'b11, 23'($urandom_range(0, 4095)), 3'd0);
            else if (r == 7) push_stray(7'($urandom));
            else if (r == 8) begin
                push_abort({1'b1, 7'($urandom)}, $urandom_range(0, 2), 7'($urandom));
                push_pkt(2'($urandom), 23'($urandom), 3'd0);
            end else begin
                push_pkt(2'($urandom), 23'($urandom), 3'($urandom_range(1, 7)));
            end
            if ($urandom_range(0, 19) == 0) drain();
            if ($urandom_range(0, 29) == 0) bp_hold = $urandom_range(3, 12);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
